cop1_xfer_seq: RTL and testbench

Multi-cycle sequencer for MTC1/MFC1 moves between the general-purpose (GP) and floating-point (FP) register files. It accepts one decoded move request at a time over a valid/ready handshake. It issues a one-cycle read to the source register file, captures the returned word, and drives a single-cycle write into the destination register file. It sits between the instruction decode stage and the two register-file ports, and owns the full transfer from request to write-back.

---
 rtl/cop1_xfer_seq.sv | 115 +++++++++++
 tb/tb_cop1_xfer_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cop1_xfer_seq.sv
// MTC1/MFC1 move sequencer: reads one register file, captures the word and writes it into
// the other file. Four cycles per transfer: IDLE -> READ -> CAPT -> WRITE.
module cop1_xfer_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_mtc1,
  input  logic [ADDR_W-1:0] req_src,
  input  logic [ADDR_W-1:0] req_dst,
  output logic              gp_rd_en,
  output logic [ADDR_W-1:0] gp_rd_addr,
  input  logic [DATA_W-1:0] gp_rd_data,
  output logic              fp_rd_en,
  output logic [ADDR_W-1:0] fp_rd_addr,
  input  logic [DATA_W-1:0] fp_rd_data,
  output logic              gp_wr_en,
  output logic [ADDR_W-1:0] gp_wr_addr,
  output logic [DATA_W-1:0] gp_wr_data,
  output logic              fp_wr_en,
  output logic [ADDR_W-1:0] fp_wr_addr,
  output logic [DATA_W-1:0] fp_wr_data,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_count
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StCapt  = 2'd2;
  localparam logic [1:0] StWrite = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              is_mtc1_q;
  logic [ADDR_W-1:0] dst_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StRead;
      StRead:  state_d = StCapt;
      StCapt:  state_d = StWrite;
      StWrite: state_d = StIdle;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      is_mtc1_q  <= 1'b0;
      dst_q      <= '0;
      gp_rd_en   <= 1'b0;
      gp_rd_addr <= '0;
      fp_rd_en   <= 1'b0;
      fp_rd_addr <= '0;
      gp_wr_en   <= 1'b0;
      gp_wr_addr <= '0;
      gp_wr_data <= '0;
      fp_wr_en   <= 1'b0;
      fp_wr_addr <= '0;
      fp_wr_data <= '0;
      done       <= 1'b0;
      xfer_count <= '0;
    end else begin
      state_q  <= state_d;
      gp_rd_en <= 1'b0;
      fp_rd_en <= 1'b0;
      gp_wr_en <= 1'b0;
      fp_wr_en <= 1'b0;
      done     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            is_mtc1_q <= req_is_mtc1;
            dst_q     <= req_dst;
            // Read strobe is registered here so it is high exactly during READ.
            if (req_is_mtc1) begin
              gp_rd_en   <= 1'b1;
              gp_rd_addr <= req_src;
            end else begin
              fp_rd_en   <= 1'b1;
              fp_rd_addr <= req_src;
            end
          end
        end
        StRead: begin
        end
        StCapt: begin
          done <= 1'b1;
          if (is_mtc1_q) begin
            fp_wr_en   <= 1'b1;
            fp_wr_addr <= dst_q;
            fp_wr_data <= gp_rd_data;
          end else begin
            // GP $0 is hardwired to zero: the transfer completes but never writes it.
            gp_wr_en   <= (dst_q != '0);
            gp_wr_addr <= dst_q;
            gp_wr_data <= fp_rd_data;
          end
        end
        StWrite: begin
          xfer_count <= xfer_count + CNT_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cop1_xfer_seq.sv
// Bench for cop1_xfer_seq: a transaction-level model predicts every output each cycle,
// with directed scenarios pinned by literal expectations and a long randomized run.
module tb_cop1_xfer_seq;

  localparam int unsigned CW = 4;  // narrow counter so wrap-around is reachable quickly

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_is_mtc1;
  logic [4:0]  req_src, req_dst;
  logic        gp_rd_en, fp_rd_en, gp_wr_en, fp_wr_en, done, busy;
  logic [4:0]  gp_rd_addr, fp_rd_addr, gp_wr_addr, fp_wr_addr;
  logic [31:0] gp_rd_data, fp_rd_data, gp_wr_data, fp_wr_data;
  logic [CW-1:0] xfer_count;

  logic [31:0] gp_mem [32];
  logic [31:0] fp_mem [32];

  int checks = 0;
  int errors = 0;

  // Transfer model: age counts edges since acceptance (1 = read, 3 = write, 4 = retired).
  bit          m_active = 1'b0;
  int          m_age = 0;
  bit          m_mtc1 = 1'b0;
  logic [4:0]  m_src = '0, m_dst = '0;
  int unsigned m_count = 0;

  cop1_xfer_seq #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_mtc1(req_is_mtc1), .req_src(req_src), .req_dst(req_dst),
    .gp_rd_en(gp_rd_en), .gp_rd_addr(gp_rd_addr), .gp_rd_data(gp_rd_data),
    .fp_rd_en(fp_rd_en), .fp_rd_addr(fp_rd_addr), .fp_rd_data(fp_rd_data),
    .gp_wr_en(gp_wr_en), .gp_wr_addr(gp_wr_addr), .gp_wr_data(gp_wr_data),
    .fp_wr_en(fp_wr_en), .fp_wr_addr(fp_wr_addr), .fp_wr_data(fp_wr_data),
    .done(done), .busy(busy), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // Register files: data valid the cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    gp_rd_data <= gp_rd_en ? gp_mem[gp_rd_addr] : $urandom;
    fp_rd_data <= fp_rd_en ? fp_mem[fp_rd_addr] : $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit rd, wr;
    rd = m_active && (m_age == 1);
    wr = m_active && (m_age == 3);
    chk("req_ready", req_ready, !m_active);
    chk("busy", busy, m_active);
    chk("gp_rd_en", gp_rd_en, rd && m_mtc1);
    chk("fp_rd_en", fp_rd_en, rd && !m_mtc1);
    if (rd && m_mtc1) chk("gp_rd_addr", gp_rd_addr, m_src);
    if (rd && !m_mtc1) chk("fp_rd_addr", fp_rd_addr, m_src);
    chk("gp_wr_en", gp_wr_en, wr && !m_mtc1 && (m_dst != 0));
    chk("fp_wr_en", fp_wr_en, wr && m_mtc1);
    chk("done", done, wr);
    if (wr && m_mtc1) begin
      chk("fp_wr_addr", fp_wr_addr, m_dst);
      chk("fp_wr_data", fp_wr_data, gp_mem[m_src]);
    end
    if (wr && !m_mtc1 && (m_dst != 0)) begin
      chk("gp_wr_addr", gp_wr_addr, m_dst);
      chk("gp_wr_data", gp_wr_data, fp_mem[m_src]);
    end
    chk("xfer_count", xfer_count, m_count);
  endtask

  task automatic model_update(input bit r, input bit v, input bit m, input logic [4:0] s,
                              input logic [4:0] d);
    if (r) begin
      m_active = 1'b0;
      m_count  = 0;
    end else if (m_active) begin
      m_age++;
      if (m_age == 4) begin
        m_active = 1'b0;
        m_count  = (m_count + 1) % (1 << CW);
      end
    end else if (v) begin
      m_active = 1'b1;
      m_age    = 1;
      m_mtc1   = m;
      m_src    = s;
      m_dst    = d;
    end
  endtask

  // One clock cycle: drive inputs, check this cycle's outputs, advance model across the edge.
  task automatic tick(input bit r, input bit v, input bit m, input logic [4:0] s,
                      input logic [4:0] d);
    rst = r; req_valid = v; req_is_mtc1 = m; req_src = s; req_dst = d;
    check_outputs();
    @(posedge clk);
    model_update(r, v, m, s, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 5'($urandom), 5'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      gp_mem[i] = ($urandom & 32'hFFFF_FF00) | 32'(i);
      fp_mem[i] = ($urandom & 32'hFFFF_FF00) | 32'h80 | 32'(i);
    end
    gp_mem[3]  = 32'hDEADBEEF;
    fp_mem[12] = 32'h3F800000;

    rst = 1'b1; req_valid = 1'b0; req_is_mtc1 = 1'b0; req_src = '0; req_dst = '0;
    @(negedge clk);
    chk("reset req_ready", req_ready, 32'd1);
    chk("reset busy", busy, 32'd0);
    chk("reset done", done, 32'd0);
    chk("reset xfer_count", xfer_count, 32'd0);

    // Reset while in CAPT: no write, no done, count stays 0.
    tick(1'b0, 1'b1, 1'b1, 5'd2, 5'd9);
    tick(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    chk("capt reset ready", req_ready, 32'd1);
    chk("capt reset busy", busy, 32'd0);
    chk("capt reset count", xfer_count, 32'd0);
    idle(3);

    // MTC1 src=3 dst=7.
    tick(1'b0, 1'b1, 1'b1, 5'd3, 5'd7);
    chk("mtc1 gp_rd_en", gp_rd_en, 32'd1);
    chk("mtc1 gp_rd_addr", gp_rd_addr, 32'd3);
    tick(1'b0, 1'b0, 1'b0, 5'd1, 5'd1);
    tick(1'b0, 1'b0, 1'b0, 5'd1, 5'd1);
    chk("mtc1 fp_wr_en", fp_wr_en, 32'd1);
    chk("mtc1 fp_wr_addr", fp_wr_addr, 32'd7);
    chk("mtc1 fp_wr_data", fp_wr_data, 32'hDEADBEEF);
    chk("mtc1 done", done, 32'd1);
    chk("mtc1 gp_wr_en", gp_wr_en, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 5'd1, 5'd1);
    chk("mtc1 count", xfer_count, 32'd1);

    // MFC1 src=12 dst=4.
    tick(1'b0, 1'b1, 1'b0, 5'd12, 5'd4);
    chk("mfc1 fp_rd_en", fp_rd_en, 32'd1);
    tick(1'b0, 1'b0, 1'b1, 5'd3, 5'd3);
    tick(1'b0, 1'b0, 1'b1, 5'd3, 5'd3);
    chk("mfc1 gp_wr_en", gp_wr_en, 32'd1);
    chk("mfc1 gp_wr_addr", gp_wr_addr, 32'd4);
    chk("mfc1 gp_wr_data", gp_wr_data, 32'h3F800000);
    chk("mfc1 fp_wr_en", fp_wr_en, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);

    // MFC1 to GP $0: completes without writing.
    tick(1'b0, 1'b1, 1'b0, 5'd5, 5'd0);
    tick(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    chk("gp0 gp_wr_en", gp_wr_en, 32'd0);
    chk("gp0 done", done, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    chk("gp0 count", xfer_count, 32'd3);

    // Three back-to-back requests with req_valid held high.
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) chk("b2b ready", req_ready, 32'd1);
      tick(1'b0, 1'b1, 1'(i / 4 != 1), 5'(8 + i / 4), 5'(16 + i / 4));
    end
    tick(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    chk("b2b count", xfer_count, 32'd6);

    // Simultaneous reset and request: not accepted.
    tick(1'b1, 1'b1, 1'b1, 5'd1, 5'd1);
    chk("rst+valid ready", req_ready, 32'd1);
    chk("rst+valid count", xfer_count, 32'd0);

    // Reset during WRITE clears a nonzero count.
    tick(1'b0, 1'b1, 1'b1, 5'd4, 5'd5);
    tick(1'b0, 1'b1, 1'b1, 5'd4, 5'd5);
    tick(1'b0, 1'b1, 1'b1, 5'd4, 5'd5);
    tick(1'b0, 1'b1, 1'b1, 5'd4, 5'd5);
    tick(1'b0, 1'b1, 1'b1, 5'd6, 5'd7);
    tick(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    chk("wr reset pre count", xfer_count, 32'd1);
    chk("wr reset done", done, 32'd1);
    tick(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    chk("wr reset count", xfer_count, 32'd0);
    chk("wr reset done clr", done, 32'd0);

    // Counter wrap: 15 transfers, then one more returns to zero.
    for (int i = 0; i < 60; i++) tick(1'b0, 1'b1, 1'b1, 5'(i / 4), 5'(i / 4));
    chk("wrap pre count", xfer_count, 32'd15);
    tick(1'b0, 1'b1, 1'b0, 5'd9, 5'd9);
    tick(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    chk("wrap done", done, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    chk("wrap count", xfer_count, 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit         r, v, m;
      logic [4:0] s, d;
      r = ($urandom_range(0, 63) == 0);
      v = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      s = 5'($urandom_range(0, 31));
      d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      tick(r, v, m, s, d);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
